// File: rtl/md_select_sequencer.sv
// Mega Drive six-button select sequencer: synchronizes TH (p7), tracks the protocol phase, restarts it on inactivity.
// Optional `MODE_LOCK_EN: latch three-button compatibility mode from md at reset release.
module md_select_sequencer #(
   parameter int TIMEOUT_CYCLES = 30000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p7,
   input  logic       md,
   output logic       sel,
   output logic [2:0] phase,
   output logic       edge_strobe,
   output logic       timeout_strobe,
   output logic       six_btn
);

   localparam logic [14:0] TIMEOUT_MAX  = 15'(TIMEOUT_CYCLES);
   localparam logic [14:0] TIMEOUT_LAST = 15'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sel_d;
   logic [14:0]            idle_cnt;
   logic                   edge_det;

   assign sel      = sync_q[SYNC_STAGES-1];
   assign edge_det = (sel != sel_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q         <= '1;
         sel_d          <= 1'b1;
         phase          <= 3'd0;
         edge_strobe    <= 1'b0;
         timeout_strobe <= 1'b0;
         idle_cnt       <= 15'd0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], p7};
         sel_d  <= sel;
         // NOTE: strobes default low with <= so a later branch in this block overrides the default cleanly.
         edge_strobe    <= 1'b0;
         timeout_strobe <= 1'b0;
         if (edge_det) begin
            edge_strobe <= 1'b1;
            idle_cnt    <= 15'd0;
            if (six_btn)
               phase <= phase + 3'd1;
            else
               phase <= {2'b00, ~sel};
         end else if (idle_cnt == TIMEOUT_LAST) begin
            // Inactivity: restart the phase and park the counter until the next edge.
            timeout_strobe <= 1'b1;
            phase          <= {2'b00, ~sel};
            idle_cnt       <= TIMEOUT_MAX;
         end else if (idle_cnt != TIMEOUT_MAX) begin
            idle_cnt <= idle_cnt + 15'd1;
         end
      end
   end

`ifdef MODE_LOCK_EN
   logic mode_locked;

   always_ff @(posedge clk) begin
      if (rst) begin
         six_btn     <= 1'b1;
         mode_locked <= 1'b0;
      end else if (!mode_locked) begin
         six_btn     <= md;
         mode_locked <= 1'b1;
      end
   end
`else
   logic unused_md;
   assign unused_md = md;
   assign six_btn   = 1'b1;
`endif

endmodule

// File: tb/tb_md_select_sequencer.sv
// Self-checking bench for md_select_sequencer: directed protocol scenarios plus random p7/reset traffic
// checked every cycle against a queue-based reference model.
module tb_md_select_sequencer;

   localparam int TMO  = 16;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p7  = 1'b1;
   logic       md  = 1'b1;
   logic       sel;
   logic [2:0] phase;
   logic       edge_strobe;
   logic       timeout_strobe;
   logic       six_btn;

   int n_checks = 0;
   int n_fail   = 0;

   md_select_sequencer #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .p7(p7), .md(md), .sel(sel), .phase(phase),
      .edge_strobe(edge_strobe), .timeout_strobe(timeout_strobe), .six_btn(six_btn)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sel is p7 delayed SYNC cycles; an edge is a change of the visible level;
   // a timeout happens when exactly TMO edge-free cycles have passed since reset or the last edge.
   bit hist[$];
   bit m_prev, m_six, exp_edge, exp_to, model_valid = 1'b0;
   int m_phase, m_since;
`ifdef MODE_LOCK_EN
   bit m_pending;
`endif

   always @(posedge clk) begin
      if (rst) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
         m_prev = 1'b1; m_phase = 0; m_since = 0; exp_edge = 1'b0; exp_to = 1'b0;
         m_six = 1'b1; model_valid = 1'b1;
`ifdef MODE_LOCK_EN
         m_pending = 1'b1;
`endif
      end else if (model_valid) begin
         bit s;
         s = hist[$];
         exp_edge = (s != m_prev);
         exp_to   = 1'b0;
         if (exp_edge) begin
            m_since = 0;
            m_phase = m_six ? (m_phase + 1) % 8 : (s ? 0 : 1);
         end else begin
            m_since++;
            if (m_since == TMO) begin
               exp_to  = 1'b1;
               m_phase = s ? 0 : 1;
            end
         end
         m_prev = s;
         hist.push_front(p7);
         void'(hist.pop_back());
`ifdef MODE_LOCK_EN
         if (m_pending) begin
            m_six = md;
            m_pending = 1'b0;
         end
`endif
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("m_sel", 32'(sel), 32'(hist[$]));
         check("m_phase", 32'(phase), 32'(m_phase));
         check("m_edge", 32'(edge_strobe), 32'(exp_edge));
         check("m_tmo", 32'(timeout_strobe), 32'(exp_to));
         check("m_six", 32'(six_btn), 32'(m_six));
         check("excl", 32'(edge_strobe & timeout_strobe), 32'd0);
      end
   end

   task automatic do_reset(input logic md_val);
      rst = 1'b1; p7 = 1'b1; md = md_val;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for the next edge_strobe; lat is the negedge count, 0 if it never arrives.
   task automatic wait_edge(output int lat);
      int k;
      lat = 0; k = 0;
      while (lat == 0 && k < 10) begin
         @(negedge clk);
         k++;
         if (edge_strobe) lat = k;
      end
   endtask

   task automatic toggle_measure(input string tag, input int exp_phase);
      int lat, cnt;
      p7 = ~p7; lat = 0; cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (edge_strobe) begin
            cnt++;
            if (lat == 0) lat = k;
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_cnt"}, 32'(cnt), 32'd1);
      check({tag, "_phase"}, 32'(phase), 32'(exp_phase));
   endtask

   initial begin
      int lat, first, cnt, ej;
      int hold;
      #100000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, first, cnt, ej, hold;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_sel", 32'(sel), 32'd1);
      check("rst_edge", 32'(edge_strobe), 32'd0);
      check("rst_tmo", 32'(timeout_strobe), 32'd0);
      check("rst_six", 32'(six_btn), 32'd1);
      rst = 1'b0;

      // Eight toggles walk the phase 1..7,0
      for (int i = 0; i < 8; i++) toggle_measure("seq", (i + 1) % 8);

      // Three toggles then idle low: timeout 16 cycles after the last edge, to phase 1, once
      do_reset(1'b1);
      toggle_measure("t31a", 1);
      toggle_measure("t31b", 2);
      p7 = 1'b0;
      wait_edge(lat);
      check("t31_lat", 32'(lat), 32'd3);
      check("t31_phase3", 32'(phase), 32'd3);
      first = 0; cnt = 0;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         if (timeout_strobe) begin
            cnt++;
            if (first == 0) first = j;
         end
      end
      check("t31_tmo_at", 32'(first), 32'd16);
      check("t31_tmo_cnt", 32'(cnt), 32'd1);
      check("t31_phase1", 32'(phase), 32'd1);

      // Edge detected exactly when the counter sits at TIMEOUT-1: edge wins
      do_reset(1'b1);
      p7 = 1'b0;
      wait_edge(lat);
      check("t32_phase1", 32'(phase), 32'd1);
      repeat (13) @(negedge clk);
      p7 = 1'b1;
      ej = 0; cnt = 0;
      for (int j = 14; j <= 20; j++) begin
         @(negedge clk);
         if (edge_strobe && ej == 0) ej = j;
         if (timeout_strobe) cnt++;
         if (j == 16) check("t32_phase2", 32'(phase), 32'd2);
      end
      check("t32_edge_at", 32'(ej), 32'd16);
      check("t32_no_tmo", 32'(cnt), 32'd0);
      // Idle high restarts to phase 0; the next falling select then gives phase 1
      cnt = 0;
      for (int j = 1; j <= 25; j++) begin
         @(negedge clk);
         if (timeout_strobe) cnt++;
      end
      check("t22_tmo_cnt", 32'(cnt), 32'd1);
      check("t22_phase0", 32'(phase), 32'd0);
      p7 = 1'b0;
      wait_edge(lat);
      check("t22_phase1", 32'(phase), 32'd1);

      // Reset in mid-sequence at phase 5 with p7 low
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) toggle_measure("t33", i + 1);
      rst = 1'b1;
      @(negedge clk);
      check("t33_rst_phase", 32'(phase), 32'd0);
      check("t33_rst_sel", 32'(sel), 32'd1);
      check("t33_rst_edge", 32'(edge_strobe), 32'd0);
      check("t33_rst_tmo", 32'(timeout_strobe), 32'd0);
      rst = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) check("t33_sel_k1", 32'(sel), 32'd1);
         if (k == 2) check("t33_sel_k2", 32'(sel), 32'd0);
         if (edge_strobe && lat == 0) begin
            lat = k;
            check("t33_phase", 32'(phase), 32'd1);
         end
      end
      check("t33_lat", 32'(lat), 32'd3);

`ifdef MODE_LOCK_EN
      // Mode held at release locks three-button mode; releasing md later changes nothing
      do_reset(1'b0);
      repeat (2) @(negedge clk);
      md = 1'b1;
      check("t34_six0", 32'(six_btn), 32'd0);
      for (int i = 0; i < 8; i++) toggle_measure("t34", (i % 2 == 0) ? 1 : 0);
      check("t34_six_still0", 32'(six_btn), 32'd0);
      do_reset(1'b1);
      repeat (2) @(negedge clk);
      check("t34_six1", 32'(six_btn), 32'd1);
`endif

      // Random traffic against the model
      do_reset(1'b1);
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         md = 1'($urandom_range(0, 1));
         if (hold == 0) begin
            p7   = ~p7;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : int'($urandom_range(0, 6));
         end else begin
            hold--;
         end
         rst = ($urandom_range(0, 499) == 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
